// File: rtl/shift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer_pkg
// Purpose  : Shared constants for the multi-cycle right-shift unit.
//            - Operand and shift-amount widths.
//            - FSM state encodings.
//            - A helper that applies sign fill to the result of a logical
//              one-bit shift.
// Revision : 1.0 - initial release
// ============================================================================
package shift_sequencer_pkg;

    // The operand width is fixed at 8 to match the one-bit shift stage.
    localparam int WIDTH = 8;
    // The maximum shift is 2**AMT_W-1 positions.
    localparam int AMT_W = 3;

    // FSM state encodings. The value 2'd3 is unused and recovers to IDLE.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // The counter value at which the current SHIFT cycle is the final one.
    localparam logic [AMT_W-1:0] C_CNT_LAST = AMT_W'(1);

    // The shift stage always brings in a zero at the MSB. When sign fill is
    // selected, that MSB is replaced by the MSB of the operand before the
    // shift.
    function automatic logic [WIDTH-1:0] fill_msb(
        input logic [WIDTH-1:0] shifted,
        input logic             sign,
        input logic             old_msb
    );
        return {(sign ? old_msb : shifted[WIDTH-1]), shifted[WIDTH-2:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_sequencer_shift_right.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer_shift_right
// Purpose  : A purely combinational single-bit logical right shift.
//            A zero enters at the MSB.
// Ports    : i_data  in   WIDTH  operand
//            o_data  out  WIDTH  operand >> 1
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer_shift_right #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    assign o_data = {1'b0, i_data[WIDTH-1:1]};

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : A multi-cycle right shifter for an 8-bit operand.
//            - Shifts by 0..7 positions, one position per clock.
//            - The fill is either logical (zero) or arithmetic (sign).
//            - The control unit drives it through a start/busy/done handshake.
// Ports    : clk       in   1      rising-edge clock
//            rst_n     in   1      asynchronous active-low reset
//            start     in   1      request, sampled only in IDLE
//            data_in   in   WIDTH  operand, captured on accepted start
//            amount    in   AMT_W  shift count, captured on accepted start
//            arith     in   1      1 = sign fill, 0 = zero fill
//            busy      out  1      high while shifting
//            done      out  1      one-cycle completion pulse
//            data_out  out  WIDTH  result, held until the next result
//            carry_out out  1      last bit shifted out (0 for amount 0)
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [AMT_W-1:0] r_cnt;
    logic             r_sign;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_data_out;
    logic             r_carry;
    logic [WIDTH-1:0] w_sr_out;
    logic [WIDTH-1:0] w_shifted;
    logic             w_accept;
    logic             w_last_shift;

    // Single-bit logical shift stage. Sign fill is layered on its MSB below.
    shift_sequencer_shift_right #(
        .WIDTH (WIDTH)
    ) u_shift_right (
        .i_data (r_work),
        .o_data (w_sr_out)
    );

    assign w_shifted    = fill_msb(w_sr_out, r_sign, r_work[WIDTH-1]);
    assign w_accept     = (r_state == ST_IDLE) && start;
    assign w_last_shift = (r_state == ST_SHIFT) && (r_cnt == C_CNT_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (amount != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work     <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data_out <= '0;
            r_carry    <= 1'b0;
        end else begin
            // busy tracks the state that is about to be entered, so the
            // output is high for exactly the cycles spent in SHIFT.
            r_busy <= (w_state_nxt == ST_SHIFT);
            // done is delayed one cycle after DONE. It pulses for one cycle,
            // and the IDLE cycle that follows can already accept a new start.
            r_done <= (r_state == ST_DONE);

            if (w_accept) begin
                r_work <= data_in;
                r_cnt  <= amount;
                r_sign <= arith;
                if (amount == '0) begin
                    r_data_out <= data_in;
                    r_carry    <= 1'b0;
                end
            end else if (r_state == ST_SHIFT) begin
                r_work  <= w_shifted;
                r_carry <= r_work[0];
                r_cnt   <= r_cnt - C_CNT_LAST;
                // data_out is written only on entry to DONE, so it holds the
                // previous result throughout the shift.
                if (w_last_shift) begin
                    r_data_out <= w_shifted;
                end
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign data_out  = r_data_out;
    assign carry_out = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer.
//            - Table-driven operations feed a result scoreboard.
//            - Hand-written sequences cover a start pulsed while shifting,
//              a back-to-back start, and a reset during a shift.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] data_in;
    logic [2:0] amount;
    logic       arith;
    logic       busy;
    logic       done;
    logic [7:0] data_out;
    logic       carry_out;

    int n_checks;
    int n_fail;
    int n_done;

    typedef struct {
        logic [7:0] data;
        logic       carry;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic [2:0] amt;
        logic       ar;
        logic [7:0] ed;
        logic       ec;
    } vec_t;

    exp_t       sb_q[$];
    logic [7:0] last_result;

    shift_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_in   (data_in),
        .amount    (amount),
        .arith     (arith),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pending result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, e.data});
                check("carry_out", {31'd0, carry_out}, {31'd0, e.carry});
            end
        end
    end

    // Launch one operation from a negedge and return at the negedge where
    // done is high. If glitch_at >= 0, a stray start carrying a different
    // operand is pulsed on that negedge count while the shift is running.
    task automatic run_op(input logic [7:0] d, input logic [2:0] amt, input logic ar,
                          input logic [7:0] ed, input logic ec, input int glitch_at);
        int   cyc;
        int   busy_cyc;
        logic held_ok;
        exp_t e;
        start   = 1'b1;
        data_in = d;
        amount  = amt;
        arith   = ar;
        e.data  = ed;
        e.carry = ec;
        sb_q.push_back(e);
        @(negedge clk);
        start    = 1'b0;
        data_in  = 8'($urandom_range(0, 255));
        amount   = 3'($urandom_range(0, 7));
        arith    = 1'($urandom_range(0, 1));
        cyc      = 0;
        busy_cyc = 0;
        held_ok  = 1'b1;
        while (!done && cyc < 20) begin
            if (busy) begin
                busy_cyc++;
                if (data_out !== last_result) held_ok = 1'b0;
            end
            if (cyc == glitch_at) begin
                start   = 1'b1;
                data_in = 8'h11;
                amount  = 3'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 20) check("timeout", 32'd1, 32'd0);
        check("latency", cyc, {29'd0, amt} + 32'd1);
        check("busy_cycles", busy_cyc, {29'd0, amt});
        check("data_out_held", {31'd0, held_ok}, 32'd1);
        last_result = ed;
    endtask

    initial begin
        vec_t vecs[8];
        int   d0;

        n_checks    = 0;
        n_fail      = 0;
        n_done      = 0;
        last_result = 8'h00;
        start       = 1'b0;
        data_in     = 8'h00;
        amount      = 3'd0;
        arith       = 1'b0;
        rst_n       = 1'b0;

        vecs[0] = '{d: 8'hB4, amt: 3'd3, ar: 1'b0, ed: 8'h16, ec: 1'b1};
        vecs[1] = '{d: 8'hB4, amt: 3'd3, ar: 1'b1, ed: 8'hF6, ec: 1'b1};
        vecs[2] = '{d: 8'h5A, amt: 3'd0, ar: 1'b0, ed: 8'h5A, ec: 1'b0};
        vecs[3] = '{d: 8'h80, amt: 3'd7, ar: 1'b0, ed: 8'h01, ec: 1'b0};
        vecs[4] = '{d: 8'h80, amt: 3'd7, ar: 1'b1, ed: 8'hFF, ec: 1'b0};
        vecs[5] = '{d: 8'h01, amt: 3'd1, ar: 1'b0, ed: 8'h00, ec: 1'b1};
        vecs[6] = '{d: 8'h7F, amt: 3'd2, ar: 1'b1, ed: 8'h1F, ec: 1'b1};
        vecs[7] = '{d: 8'hFF, amt: 3'd7, ar: 1'b0, ed: 8'h01, ec: 1'b1};

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_data_out", {24'd0, data_out}, 32'd0);
        check("rst_carry_out", {31'd0, carry_out}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven operations, with idle gaps between them.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].d, vecs[i].amt, vecs[i].ar, vecs[i].ed, vecs[i].ec, -1);
            @(negedge clk);
            check("done_single_cycle", {31'd0, done}, 32'd0);
            @(negedge clk);
        end

        // A stray start during SHIFT must be ignored: one result, one done.
        d0 = n_done;
        run_op(8'hF0, 3'd4, 1'b0, 8'h0F, 1'b0, 1);
        // Back-to-back: the start is issued in the cycle where done is high.
        run_op(8'hB4, 3'd3, 1'b1, 8'hF6, 1'b1, -1);
        repeat (4) @(negedge clk);
        check("done_pulses_glitch_b2b", n_done - d0, 32'd2);

        // Reset asserted mid-SHIFT clears the outputs at once, with no done.
        d0 = n_done;
        start   = 1'b1;
        data_in = 8'hB4;
        amount  = 3'd7;
        arith   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_data_out", {24'd0, data_out}, 32'd0);
        check("async_rst_carry_out", {31'd0, carry_out}, 32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_result = 8'h00;
        repeat (10) @(negedge clk);
        check("no_done_after_abort", n_done - d0, 32'd0);

        run_op(8'hC3, 3'd2, 1'b0, 8'h30, 1'b1, -1);
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
